// File: rtl/io_uart_tx.sv
// Generic synchronous FIFO used as the transmit byte queue.
// Latency: a push is visible on rd_dat/count one cycle later; rd_dat is the head, read combinationally.
// Backpressure: pushes while full and pops while empty are ignored; full is judged before a same-cycle pop.
module io_uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  wr_dat,
  input  logic          pop,
  output logic [W-1:0]  rd_dat,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_dat  = mem[rd_ptr];

  // Storage array; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_dat;
  end

  // Pointers wrap naturally modulo DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// Memory-mapped 8N1 serial transmitter in the SOC IO window (TXDATA/STATUS/CTRL).
// Latency: reads answer one cycle after the request; a byte written to an idle line starts one cycle later.
// Backpressure: none toward the bus; bytes written while the FIFO is full are dropped and set STATUS.ovf.
module io_uart_tx #(
  parameter logic [31:0] BASE        = 32'h0000_1000,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        isIO,
  input  logic [31:0] port,
  input  logic [3:0]  size,
  input  logic [1:0]  pulse,
  input  logic        rw,
  input  logic [63:0] data_in,
  output logic [63:0] data_out,
  output logic        data_oe,
  output logic        tx,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // Bus decode
  logic          sel;
  logic          wr_en;
  logic          rd_en;
  logic [1:0]    reg_idx;
  logic          push;

  // Control / status registers
  logic [15:0]   div;
  logic          irq_en;
  logic          ovf;
  logic [63:0]   rd_val;

  // FIFO interface
  logic          fifo_pop;
  logic [7:0]    fifo_dat;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    count8;

  // Serializer state
  state_t        state;
  state_t        state_nxt;
  logic [7:0]    shreg;
  logic [7:0]    shreg_nxt;
  logic [15:0]   bit_cnt;
  logic [15:0]   bit_cnt_nxt;
  logic [15:0]   div_lat;
  logic [15:0]   div_lat_nxt;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_idx_nxt;
  logic          load_frame;
  logic          tx_nxt;
  logic          busy;

  // Bus bits with no function in this block.
  logic          unused_bits;
  assign unused_bits = ^{pulse[1], port[2:0], data_in[63:17]};

  assign sel     = isIO & pulse[0] & (size != 4'd0) & (port[31:5] == BASE[31:5]);
  assign wr_en   = sel & rw;
  assign rd_en   = sel & ~rw;
  assign reg_idx = port[4:3];
  assign push    = wr_en & (reg_idx == REG_TXDATA);
  assign count8  = 8'(fifo_count);
  assign busy    = (state != ST_IDLE);
  assign irq     = fifo_empty & ~busy & irq_en;

  io_uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .wr_dat (data_in[7:0]),
    .pop    (fifo_pop),
    .rd_dat (fifo_dat),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // Programmable registers and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      div    <= DEFAULT_DIV;
      irq_en <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      // FIFO full is sampled before any pop in this cycle, so push+pop while full still drops.
      if (push & fifo_full) ovf <= 1'b1;
      if (wr_en & (reg_idx == REG_STATUS) & data_in[3]) ovf <= 1'b0;
      if (wr_en & (reg_idx == REG_CTRL)) begin
        div    <= data_in[15:0];
        irq_en <= data_in[16];
      end
    end
  end

  // Read mux over the register file; unused and write-only registers read as zero.
  always_comb begin
    rd_val = '0;
    case (reg_idx)
      REG_STATUS: begin
        rd_val[0]    = fifo_full;
        rd_val[1]    = fifo_empty;
        rd_val[2]    = busy;
        rd_val[3]    = ovf;
        rd_val[15:8] = count8;
      end
      REG_CTRL: begin
        rd_val[15:0] = div;
        rd_val[16]   = irq_en;
      end
      default: rd_val = '0;
    endcase
  end

  // Registered read port: data and enable are live for exactly one cycle per read.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= '0;
      data_oe  <= 1'b0;
    end else begin
      data_oe  <= rd_en;
      data_out <= rd_en ? rd_val : '0;
    end
  end

  // Serializer state register; tx is registered from the next-state view so the pin is glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      div_lat <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
      div_lat <= div_lat_nxt;
      bit_idx <= bit_idx_nxt;
      tx      <= tx_nxt;
    end
  end

  // Next-state logic: each bit lasts div_lat+1 cycles; div is captured only when a frame starts.
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    div_lat_nxt = div_lat;
    bit_idx_nxt = bit_idx;
    load_frame  = 1'b0;
    fifo_pop    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!fifo_empty) load_frame = 1'b1;
      end
      ST_START: begin
        if (bit_cnt == 16'd0) begin
          bit_cnt_nxt = div_lat;
          bit_idx_nxt = 3'd0;
          state_nxt   = ST_DATA;
        end else begin
          bit_cnt_nxt = bit_cnt - 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_cnt == 16'd0) begin
          bit_cnt_nxt = div_lat;
          shreg_nxt   = {1'b0, shreg[7:1]};
          if (bit_idx == 3'd7) begin
            state_nxt = ST_STOP;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end else begin
          bit_cnt_nxt = bit_cnt - 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_cnt == 16'd0) begin
          // Chain straight into the next start bit when more data is waiting.
          if (!fifo_empty) begin
            load_frame = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          bit_cnt_nxt = bit_cnt - 16'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (load_frame) begin
      fifo_pop    = 1'b1;
      shreg_nxt   = fifo_dat;
      div_lat_nxt = div;
      bit_cnt_nxt = div;
      state_nxt   = ST_START;
    end

    case (state_nxt)
      ST_START: tx_nxt = 1'b0;
      ST_DATA:  tx_nxt = shreg_nxt[0];
      default:  tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// Bench for io_uart_tx: randomized bus traffic against a line-waveform reference model.
// The model expands each popped byte into its per-cycle tx values and tracks the register file.
// Outputs are compared every cycle on the falling edge, plus literal spot checks.
module tb_io_uart_tx;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        isIO;
  logic [31:0] port;
  logic [3:0]  size;
  logic [1:0]  pulse;
  logic        rw;
  logic [63:0] data_in;
  logic [63:0] data_out;
  logic        data_oe;
  logic        tx;
  logic        irq;

  io_uart_tx #(
    .BASE        (BASE),
    .FIFO_DEPTH  (DEPTH),
    .DEFAULT_DIV (16'd867)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .isIO     (isIO),
    .port     (port),
    .size     (size),
    .pulse    (pulse),
    .rw       (rw),
    .data_in  (data_in),
    .data_out (data_out),
    .data_oe  (data_oe),
    .tx       (tx),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [7:0]  m_fifo[$];
  bit          m_line[$];
  logic [15:0] m_div;
  bit          m_irq_en;
  bit          m_ovf;
  logic        exp_tx;
  logic        exp_irq;
  logic        exp_oe;
  logic [63:0] exp_dout;
  bit          chk_en = 1'b0;

  bit          mdl_sel;
  bit          mdl_busy_pre;
  bit          mdl_full_pre;
  logic [63:0] mdl_rd;
  logic [7:0]  mdl_b;
  int          mdl_d;

  // Model: one step per rising edge, using the inputs that edge samples.
  always @(posedge clk) begin
    if (reset) begin
      m_fifo.delete();
      m_line.delete();
      m_div    = 16'd867;
      m_irq_en = 1'b0;
      m_ovf    = 1'b0;
      exp_tx   = 1'b1;
      exp_irq  = 1'b0;
      exp_oe   = 1'b0;
      exp_dout = '0;
    end else begin
      mdl_sel      = isIO && pulse[0] && (size != 4'd0) && (port[31:5] == BASE[31:5]);
      mdl_busy_pre = (m_line.size() != 0);
      mdl_full_pre = (m_fifo.size() == DEPTH);
      mdl_rd = '0;
      if (port[4:3] == 2'd1) begin
        mdl_rd[0]    = mdl_full_pre;
        mdl_rd[1]    = (m_fifo.size() == 0);
        mdl_rd[2]    = mdl_busy_pre;
        mdl_rd[3]    = m_ovf;
        mdl_rd[15:8] = 8'(m_fifo.size());
      end else if (port[4:3] == 2'd3) begin
        mdl_rd[15:0] = m_div;
        mdl_rd[16]   = m_irq_en;
      end
      exp_oe   = mdl_sel && !rw;
      exp_dout = exp_oe ? mdl_rd : 64'd0;
      // The line value of the cycle that just ended is consumed.
      if (m_line.size() != 0) void'(m_line.pop_front());
      if (m_line.size() == 0 && m_fifo.size() != 0) begin
        mdl_b = m_fifo.pop_front();
        mdl_d = int'(m_div);
        for (int c = 0; c <= mdl_d; c++) m_line.push_back(1'b0);
        for (int i = 0; i < 8; i++)
          for (int c = 0; c <= mdl_d; c++) m_line.push_back(mdl_b[i]);
        for (int c = 0; c <= mdl_d; c++) m_line.push_back(1'b1);
      end
      if (mdl_sel && rw) begin
        case (port[4:3])
          2'd0: if (mdl_full_pre) m_ovf = 1'b1; else m_fifo.push_back(data_in[7:0]);
          2'd1: if (data_in[3]) m_ovf = 1'b0;
          2'd3: begin
            m_div    = data_in[15:0];
            m_irq_en = data_in[16];
          end
          default: ;
        endcase
      end
      exp_tx  = (m_line.size() != 0) ? m_line[0] : 1'b1;
      exp_irq = (m_fifo.size() == 0) && (m_line.size() == 0) && m_irq_en;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("tx", 64'(tx), 64'(exp_tx));
      chk("irq", 64'(irq), 64'(exp_irq));
      chk("data_oe", 64'(data_oe), 64'(exp_oe));
      chk("data_out", data_out, exp_dout);
    end
  end

  function automatic logic [3:0] rsize();
    case ($urandom_range(0, 3))
      0:       return 4'd1;
      1:       return 4'd2;
      2:       return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [31:0] addr(input int r);
    return BASE + 32'(r * 8) + 32'($urandom_range(0, 7));
  endfunction

  // One bus cycle starting at a falling edge; returns at the next falling edge.
  task automatic bus(input bit io, input logic [1:0] pl, input logic [3:0] sz, input bit w,
                     input logic [31:0] p, input logic [63:0] d);
    isIO = io; pulse = pl; size = sz; rw = w; port = p; data_in = d;
    @(negedge clk);
    isIO = 1'b0; pulse = 2'b00; size = 4'd0; rw = 1'b0;
    port = $urandom; data_in = {$urandom, $urandom};
  endtask

  task automatic wr(input int r, input logic [63:0] d);
    bus(1'b1, {1'($urandom_range(0, 1)), 1'b1}, rsize(), 1'b1, addr(r), d);
  endtask

  task automatic rd(input int r, output logic [63:0] v);
    bus(1'b1, {1'($urandom_range(0, 1)), 1'b1}, rsize(), 1'b0, addr(r), {$urandom, $urandom});
    v = data_out;
  endtask

  task automatic drain(input string name);
    logic [63:0] v;
    for (int i = 0; i < 6000 && (m_fifo.size() != 0 || m_line.size() != 0); i++) @(negedge clk);
    @(negedge clk);
    rd(1, v);
    chk(name, 64'(v[2:0]), 64'h2);
  endtask

  function automatic logic [63:0] rand_ctrl();
    logic [63:0] d;
    d = {$urandom, $urandom};
    d[15:0] = 16'($urandom_range(0, 3));
    return d;
  endfunction

  initial begin
    logic [63:0] v;
    bit          pat[10];
    int          op;
    int          k;
    reset = 1'b1; isIO = 1'b0; pulse = 2'b00; size = 4'd0; rw = 1'b0; port = '0; data_in = '0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    reset  = 1'b0;

    // Reset values
    rd(1, v); chk("reset_status", v, 64'h2);
    rd(3, v); chk("reset_ctrl", v, 64'h363);
    chk("reset_tx", 64'(tx), 64'h1);
    chk("reset_irq", 64'(irq), 64'h0);

    // DIV=3, single byte 0xA5
    pat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    wr(3, 64'h3);
    wr(0, 64'hA5);
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("a5_bit%0d", i), 64'(tx), 64'(pat[i / 4]));
      @(negedge clk);
    end
    rd(1, v); chk("a5_done_status", v, 64'h2);
    chk("irq_disabled", 64'(irq), 64'h0);
    wr(3, 64'h1_0003);
    chk("irq_enabled", 64'(irq), 64'h1);

    // Overflow: long first frame stalls the FSM, DIV=0 queued behind it
    wr(3, 64'd200);
    wr(0, 64'h11);
    wr(3, 64'd0);
    for (int i = 0; i < 17; i++) wr(0, 64'($urandom_range(0, 255)));
    rd(1, v); chk("ovf_status", v, 64'h100D);
    wr(1, 64'h08);
    rd(1, v); chk("ovf_cleared", v, 64'h1005);
    drain("drain_ovf");

    // Back-to-back frames 0x00 then 0xFF at DIV=1
    wr(3, 64'd1);
    wr(0, 64'h00);
    wr(0, 64'hFF);
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("b2b_bit%0d", i), 64'(tx),
          (i < 18) ? 64'h0 : (i < 20) ? 64'h1 : (i < 22) ? 64'h0 : 64'h1);
      @(negedge clk);
    end
    drain("drain_b2b");

    // Reset in the middle of a frame with more bytes waiting
    wr(3, 64'd2);
    wr(0, 64'h3C); wr(0, 64'h5A); wr(0, 64'hC3); wr(0, 64'h96);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midframe_reset_tx", 64'(tx), 64'h1);
    rd(1, v); chk("midframe_reset_status", v, 64'h2);
    repeat (50) @(negedge clk);
    chk("midframe_reset_line_idle", 64'(tx), 64'h1);
    rd(3, v); chk("midframe_reset_ctrl", v, 64'h363);

    // Accesses that must be ignored
    bus(1'b0, 2'b01, 4'd4, 1'b1, BASE, 64'h55);
    bus(1'b1, 2'b10, 4'd4, 1'b1, BASE, 64'h55);
    bus(1'b1, 2'b01, 4'd0, 1'b1, BASE, 64'h55);
    bus(1'b1, 2'b01, 4'd4, 1'b1, BASE + 32'd32, 64'h55);
    bus(1'b1, 2'b01, 4'd4, 1'b1, BASE - 32'd8, 64'h55);
    bus(1'b0, 2'b01, 4'd4, 1'b0, BASE + 32'd8, 64'h0);
    bus(1'b1, 2'b01, 4'd0, 1'b0, BASE + 32'd8, 64'h0);
    bus(1'b1, 2'b01, 4'd4, 1'b0, BASE + 32'd40, 64'h0);
    rd(1, v); chk("ignored_no_push", v, 64'h2);
    wr(2, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(2, v); chk("reserved_reads_zero", v, 64'h0);
    rd(0, v); chk("txdata_reads_zero", v, 64'h0);
    wr(3, 64'hFFFF_FFFF_FFFE_0005);
    rd(3, v); chk("ctrl_upper_bits", v, 64'h5);

    // Randomized traffic
    wr(3, rand_ctrl());
    for (int n = 0; n < 800; n++) begin
      op = $urandom_range(0, 99);
      if (op < 35) wr(0, {$urandom, $urandom});
      else if (op < 45) rd($urandom_range(0, 3), v);
      else if (op < 52) wr(3, rand_ctrl());
      else if (op < 57) wr(1, {$urandom, $urandom});
      else if (op < 60) wr(2, {$urandom, $urandom});
      else if (op < 66) begin
        k = $urandom_range(0, 3);
        case (k)
          0: bus(1'b0, 2'b01, rsize(), 1'($urandom_range(0, 1)), addr($urandom_range(0, 3)), {$urandom, $urandom});
          1: bus(1'b1, 2'b10, rsize(), 1'($urandom_range(0, 1)), addr($urandom_range(0, 3)), {$urandom, $urandom});
          2: bus(1'b1, 2'b01, 4'd0, 1'($urandom_range(0, 1)), addr($urandom_range(0, 3)), {$urandom, $urandom});
          default: bus(1'b1, 2'b01, rsize(), 1'($urandom_range(0, 1)),
                       BASE + 32'd32 + 32'($urandom_range(0, 200)), {$urandom, $urandom});
        endcase
      end else if (op < 67) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wr(3, rand_ctrl());
      end else begin
        repeat ($urandom_range(1, 5)) @(negedge clk);
      end
    end
    drain("drain_random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
